// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the FSM state encoding, the oversampling constants and the
// default frame-format parameters, so both directions agree on them.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE      = 16;
  localparam int MID_TICK        = 7;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle (typically the RX FIFO write side).
//   dout         received data, right-aligned
//   rx_done_tick one-clk strobe, frame complete
//   frame_err    stop bit sampled low in last frame
//   parity_err   parity mismatch in last frame
//   busy         receiver is not idle
// master: driven by the receiver; slave: observed by the consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (output dout, rx_done_tick, frame_err, parity_err, busy);
  modport slave  (input  dout, rx_done_tick, frame_err, parity_err, busy);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk   system clock
//   reset asynchronous, active-high reset; both flops load RESET_VAL
//   d     asynchronous input
//   q     synchronised output, two clk cycles of latency
module uart_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // A serial line idles high, so resetting to 1 keeps the receiver from
  // seeing a false start bit as reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start bit, DBIT data bits LSB first,
// optional parity bit, stop bit. Samples each bit at mid-bit and rejects
// start-bit glitches shorter than half a bit.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   rx     raw serial line, asynchronous, idle high
//   s_tick oversample tick, 16 per bit period
//   bus    data, done strobe, error flags and busy (uart_rx_if.master)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int SB_TICK    = SB_TICK_DEFAULT,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  input  logic      s_tick,
  uart_rx_if.master bus
);

  // 1.5 and 2 stop bits need 24/32 ticks, which a 4-bit counter cannot reach.
  localparam int             S_W    = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST = 3'(DBIT - 1);
  localparam int             PAD    = 8 - DBIT;

  state_t         state;
  logic [S_W-1:0] s;
  logic [2:0]     n;
  logic [7:0]     b;
  logic           pbit;
  logic           rx_s;
  logic [7:0]     dout_r;
  logic           frame_err_r;
  logic           parity_err_r;
  logic [7:0]     data;
  logic           stop_done;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Bits shift in from the top, so with fewer than 8 data bits the frame
  // sits in the upper DBIT bits and the low bits hold stale data.
  assign data      = b >> PAD;
  assign stop_done = (state == ST_STOP) && s_tick && (s == S_STOP);

  assign bus.rx_done_tick = stop_done;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.dout         = dout_r;
  assign bus.frame_err    = frame_err_r;
  assign bus.parity_err   = parity_err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      pbit         <= 1'b0;
      dout_r       <= '0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s     <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            // Half a bit in: a line that has gone high again was a glitch.
            if (s == S_MID) begin
              s <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_DATA;
                n     <= '0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= {rx_s, b[7:1]};
              if (n == N_LAST) begin
                state <= PARITY_EN ? ST_PARITY : ST_STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              pbit  <= rx_s;
              state <= ST_STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= ST_IDLE;
              s            <= '0;
              dout_r       <= data;
              frame_err_r  <= ~rx_s;
              parity_err_r <= PARITY_EN & (^data ^ pbit ^ PARITY_ODD);
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
